// File: rtl/switch_toggle_bank.sv
`default_nettype none
// switch_toggle_bank: per-channel synchronise, debounce and LED toggle, with a
// shared long-press clear that zeroes every LED.
module switch_toggle_bank #(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int EDGE_MODE       = 0,
  parameter int HOLD_CYCLES     = 50000000
) (
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  input  logic [NUM_CH-1:0] i_Switch,
  output logic [NUM_CH-1:0] o_LED,
  output logic [NUM_CH-1:0] o_Event,
  output logic              o_Clear
);

  localparam int            CW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam int            HW        = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = (HOLD_CYCLES > 0) ? HW'(HOLD_CYCLES - 1) : '0;

  logic [NUM_CH-1:0] toggle;
  logic [NUM_CH-1:0] fire;
  logic              clear_now;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]    sync;
    logic          deb;
    logic [CW-1:0] cnt;
    logic          settle;
    logic          held;

    // settle is the edge on which the debounced level adopts the synchronised one
    assign settle = (sync[1] != deb) && (cnt == DB_LAST);

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
        sync <= '0;
        deb  <= 1'b0;
        cnt  <= '0;
      end else begin
        sync <= {sync[0], i_Switch[i]};
        if (sync[1] == deb) begin
          cnt <= '0;
        end else if (settle) begin
          deb <= sync[1];
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    if (HOLD_CYCLES > 0) begin : g_hold
      logic [HW-1:0] hcnt;
      logic          held_q;

      assign fire[i] = deb && !held_q && (hcnt == HOLD_LAST);
      assign held    = held_q;

      // Counter saturates; held_q blocks a second clear until the button is released
      always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
          hcnt   <= '0;
          held_q <= 1'b0;
        end else if (!deb) begin
          hcnt   <= '0;
          held_q <= 1'b0;
        end else begin
          if (hcnt != HOLD_LAST) hcnt <= hcnt + 1'b1;
          if (fire[i]) held_q <= 1'b1;
        end
      end
    end else begin : g_no_hold
      assign fire[i] = 1'b0;
      assign held    = 1'b0;
    end

    assign toggle[i] = settle && ((EDGE_MODE != 0) ? sync[1] : (!sync[1] && !held));
  end

  assign clear_now = |fire;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_LED   <= '0;
      o_Event <= '0;
      o_Clear <= 1'b0;
    end else begin
      o_Clear <= clear_now;
      if (clear_now) begin
        o_LED   <= '0;
        o_Event <= '0;
      end else begin
        o_LED   <= o_LED ^ toggle;
        o_Event <= toggle;
      end
    end
  end

endmodule
`default_nettype wire
